// File: rtl/lock_pkg.sv
// Shared constants and FSM state type for the lock-register restore block.
// Lock registers are fail-secure: every bit set means "locked".
package lock_pkg;

  localparam int NUM_LCKS        = 6;
  localparam int LCK_W           = 32;
  localparam int IDX_W           = 3;
  localparam int CNT_W           = 8;
  localparam int RESTORE_TIMEOUT = 255;

  localparam logic [LCK_W-1:0] LCK_SECURE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RESTORE_REQ,
    RESTORE_WAIT,
    READY,
    FAIL
  } lock_state_e;

endpackage

// File: rtl/reg_lock_restore.sv
// Lock registers restored from retention storage after a power-state exit;
// software may only set further lock bits once the restore has completed.
module reg_lock_restore
  import lock_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_low,
  input  logic                           wake_i,
  output logic                           ret_req_o,
  output logic [IDX_W-1:0]               ret_idx_o,
  input  logic                           ret_ack_i,
  input  logic [LCK_W-1:0]               ret_data_i,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [IDX_W-1:0]               wr_idx_i,
  input  logic [LCK_W-1:0]               wr_data_i,
  output logic                           wr_err_o,
  output logic [NUM_LCKS-1:0][LCK_W-1:0] register_lcks,
  output logic                           locks_ready_o,
  output logic                           restore_err_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LCKS - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RESTORE_TIMEOUT - 1);

  lock_state_e                    state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [NUM_LCKS-1:0][LCK_W-1:0] lcks_d;
  logic                           wr_err_d;
  logic                           rerr_set;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    lcks_d   = register_lcks;
    wr_err_d = 1'b0;
    rerr_set = 1'b0;

    // wake_i pre-empts any ack or write arriving in the same cycle
    if (wake_i) begin
      state_d = RESTORE_REQ;
      idx_d   = '0;
      cnt_d   = '0;
      lcks_d  = {NUM_LCKS{LCK_SECURE}};
    end else begin
      case (state_q)
        RESTORE_REQ: begin
          cnt_d   = '0;
          state_d = RESTORE_WAIT;
        end
        RESTORE_WAIT: begin
          if (ret_ack_i) begin
            for (int i = 0; i < NUM_LCKS; i++) begin
              if (idx_q == IDX_W'(i)) lcks_d[i] = ret_data_i;
            end
            cnt_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = READY;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = RESTORE_REQ;
            end
          end else begin
            cnt_d = sat_inc(cnt_q);
            // this is the 255th cycle spent waiting without an ack
            if (cnt_q == TMO_LAST) begin
              state_d  = FAIL;
              rerr_set = 1'b1;
            end
          end
        end
        READY: begin
          if (wr_valid_i) begin
            if (wr_idx_i <= LAST_IDX) begin
              for (int i = 0; i < NUM_LCKS; i++) begin
                if (wr_idx_i == IDX_W'(i)) lcks_d[i] = register_lcks[i] | wr_data_i;
              end
            end else begin
              wr_err_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_low) begin
      state_q       <= RESTORE_REQ;
      idx_q         <= '0;
      cnt_q         <= '0;
      register_lcks <= {NUM_LCKS{LCK_SECURE}};
      wr_err_o      <= 1'b0;
      restore_err_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      register_lcks <= lcks_d;
      wr_err_o      <= wr_err_d;
      if (rerr_set) restore_err_o <= 1'b1;
    end
  end

  assign ret_req_o     = (state_q == RESTORE_WAIT);
  assign ret_idx_o     = idx_q;
  assign wr_ready_o    = (state_q == READY);
  assign locks_ready_o = (state_q == READY);

endmodule
